// File: rtl/mem_arbiter.sv
// Two-requester (I-cache / D-cache) arbiter onto a single shared memory port.
// One transaction outstanding at a time; ties alternate against the most recent grant.
module mem_arbiter #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [15:0]       i_addr,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [15:0]       d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [15:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [CNT_W-1:0]  i_grant_cnt,
  output logic [CNT_W-1:0]  d_grant_cnt,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t            stateReg, stateNext;
  logic              lastGrantReg;  // 0: I granted most recently, 1: D
  logic              memEnReg, memWrReg;
  logic [15:0]       memAddrReg;
  logic [DATA_W-1:0] memWdataReg;
  logic              iDoneReg, dDoneReg;
  logic [DATA_W-1:0] iRdataReg, dRdataReg;
  logic [CNT_W-1:0]  iCntReg, dCntReg;
  logic              errReg;

  logic iElig, dElig, grantI, grantD, memAccept, memStray;

  // A requester is ineligible in its own done cycle, so it cannot be re-granted
  // on the stale request it is still holding.
  assign iElig  = i_req && !iDoneReg;
  assign dElig  = d_req && !dDoneReg;
  assign grantD = (stateReg == IDLE) && dElig && (!iElig || !lastGrantReg);
  assign grantI = (stateReg == IDLE) && iElig && !grantD;

  // Completion is only honoured once the command strobe has been seen by memory.
  assign memAccept = mem_done && !memEnReg && (stateReg != IDLE);
  assign memStray  = mem_done && ((stateReg == IDLE) || memEnReg);

  always_ff @(posedge clk) begin
    if (rst) stateReg <= IDLE;
    else     stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    busy      = 1'b0;
    case (stateReg)
      IDLE: begin
        if (grantD)      stateNext = BUSY_D;
        else if (grantI) stateNext = BUSY_I;
      end
      BUSY_I, BUSY_D: begin
        busy = 1'b1;
        if (memAccept) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lastGrantReg <= 1'b0;
      memEnReg     <= 1'b0;
      memWrReg     <= 1'b0;
      memAddrReg   <= '0;
      memWdataReg  <= '0;
      iDoneReg     <= 1'b0;
      dDoneReg     <= 1'b0;
      iRdataReg    <= '0;
      dRdataReg    <= '0;
      iCntReg      <= '0;
      dCntReg      <= '0;
      errReg       <= 1'b0;
    end else begin
      memEnReg <= grantI || grantD;
      iDoneReg <= memAccept && (stateReg == BUSY_I);
      dDoneReg <= memAccept && (stateReg == BUSY_D);
      if (memStray) errReg <= 1'b1;

      if (grantD) begin
        lastGrantReg <= 1'b1;
        memWrReg     <= d_wr;
        memAddrReg   <= d_addr;
        memWdataReg  <= d_wdata;
        if (dCntReg != '1) dCntReg <= dCntReg + 1'b1;
      end else if (grantI) begin
        lastGrantReg <= 1'b0;
        memWrReg     <= 1'b0;
        memAddrReg   <= i_addr;
        memWdataReg  <= '0;
        if (iCntReg != '1) iCntReg <= iCntReg + 1'b1;
      end

      if (memAccept && (stateReg == BUSY_I)) iRdataReg <= mem_rdata;
      if (memAccept && (stateReg == BUSY_D) && !memWrReg) dRdataReg <= mem_rdata;
    end
  end

  assign mem_en      = memEnReg;
  assign mem_wr      = memWrReg;
  assign mem_addr    = memAddrReg;
  assign mem_wdata   = memWdataReg;
  assign i_done      = iDoneReg;
  assign d_done      = dDoneReg;
  assign i_rdata     = iRdataReg;
  assign d_rdata     = dRdataReg;
  assign i_grant_cnt = iCntReg;
  assign d_grant_cnt = dCntReg;
  assign err         = errReg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected commands/completions are queued by the
// stimulus, and a negedge monitor pops them as the DUT presents mem_en / x_done.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic        mem_done = 1'b0;
  logic [15:0] mem_rdata = '0;

  logic        i_done, d_done, mem_en, mem_wr, busy, err;
  logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata, i_grant_cnt, d_grant_cnt;

  logic        i_done2, d_done2, mem_en2, mem_wr2, busy2, err2;
  logic [15:0] i_rdata2, d_rdata2, mem_addr2, mem_wdata2;
  logic [1:0]  i_grant_cnt2, d_grant_cnt2;

  mem_arbiter #(.DATA_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .busy(busy), .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt), .err(err)
  );

  // Narrow-counter copy sharing all inputs, used for the saturation case.
  mem_arbiter #(.DATA_W(16), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done2), .i_rdata(i_rdata2),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done2), .d_rdata(d_rdata2),
    .mem_en(mem_en2), .mem_wr(mem_wr2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .busy(busy2), .i_grant_cnt(i_grant_cnt2), .d_grant_cnt(d_grant_cnt2), .err(err2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } cmd_t;

  cmd_t        cmdQ[$];
  logic [15:0] iQ[$];
  logic [15:0] dQ[$];
  logic [15:0] memArr[logic [15:0]];

  int checks = 0;
  int errors = 0;
  int memLat = 1;
  bit strayPulse = 0;

  function automatic cmd_t mkCmd(input logic wr, input logic [15:0] addr, input logic [15:0] wdata);
    cmd_t c;
    c.wr = wr; c.addr = addr; c.wdata = wdata;
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("FAIL %s t=%0t", name, $time);
  endtask

  // Monitor: pops an expectation every time the DUT presents a command or completion.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_en) begin
        if (cmdQ.size() == 0) failNow("mem_en_unexpected");
        else begin
          cmd_t c;
          c = cmdQ.pop_front();
          check("cmd_wr", {31'b0, mem_wr}, {31'b0, c.wr});
          check("cmd_addr", {16'b0, mem_addr}, {16'b0, c.addr});
          if (c.wr) check("cmd_wdata", {16'b0, mem_wdata}, {16'b0, c.wdata});
          $display("cmd wr=%0b addr=%h wdata=%h", mem_wr, mem_addr, mem_wdata);
        end
      end
      if (i_done) begin
        if (iQ.size() == 0) failNow("i_done_unexpected");
        else begin
          logic [15:0] e;
          e = iQ.pop_front();
          check("i_rdata", {16'b0, i_rdata}, {16'b0, e});
          $display("i_done rdata=%h", i_rdata);
        end
      end
      if (d_done) begin
        if (dQ.size() == 0) failNow("d_done_unexpected");
        else begin
          logic [15:0] e;
          e = dQ.pop_front();
          check("d_rdata", {16'b0, d_rdata}, {16'b0, e});
          $display("d_done rdata=%h", d_rdata);
        end
      end
    end
  end

  // Memory model: mem_done memLat cycles after mem_en; checks command stability meanwhile.
  logic        pending = 0;
  int          cnt = 0;
  logic        capWr;
  logic [15:0] capAddr, capWdata;
  always @(negedge clk) begin
    mem_done = 1'b0;
    if (rst) pending = 0;
    else begin
      if (pending) begin
        check("hold_addr", {16'b0, mem_addr}, {16'b0, capAddr});
        check("hold_wr", {31'b0, mem_wr}, {31'b0, capWr});
        if (capWr) check("hold_wdata", {16'b0, mem_wdata}, {16'b0, capWdata});
        if (cnt <= 1) begin
          mem_done = 1'b1;
          if (capWr) memArr[capAddr] = capWdata;
          else mem_rdata = memArr.exists(capAddr) ? memArr[capAddr] : 16'h0000;
          pending = 0;
        end else cnt--;
      end
      if (mem_en) begin
        pending  = 1;
        cnt      = memLat;
        capWr    = mem_wr;
        capAddr  = mem_addr;
        capWdata = mem_wdata;
      end
    end
    if (strayPulse) begin
      mem_done   = 1'b1;
      strayPulse = 0;
    end
  end

  task automatic doI(input logic [15:0] addr, input bit last, output int lat);
    i_req = 1'b1;
    i_addr = addr;
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      lat++;
      if (i_done) break;
    end
    if (!i_done) failNow("i_timeout");
    if (last) i_req = 1'b0;
  endtask

  task automatic doD(input logic [15:0] addr, input logic wr, input logic [15:0] wdata,
                     input bit last, output int lat);
    d_req = 1'b1;
    d_wr = wr;
    d_addr = addr;
    d_wdata = wdata;
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      lat++;
      if (d_done) break;
    end
    if (!d_done) failNow("d_timeout");
    if (last) d_req = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    i_req = 1'b0;
    d_req = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_mem_en", {31'b0, mem_en}, 32'd0);
    check("rst_i_done", {31'b0, i_done}, 32'd0);
    check("rst_d_done", {31'b0, d_done}, 32'd0);
    check("rst_i_rdata", {16'b0, i_rdata}, 32'd0);
    check("rst_d_rdata", {16'b0, d_rdata}, 32'd0);
    check("rst_i_cnt", {16'b0, i_grant_cnt}, 32'd0);
    check("rst_d_cnt", {16'b0, d_grant_cnt}, 32'd0);
    check("rst_i_cnt2", {30'b0, i_grant_cnt2}, 32'd0);
    rst = 1'b0;
  endtask

  task automatic drainCheck(input string name);
    repeat (3) @(negedge clk);
    check({name, "_cmdQ"}, cmdQ.size(), 32'd0);
    check({name, "_iQ"}, iQ.size(), 32'd0);
    check({name, "_dQ"}, dQ.size(), 32'd0);
    check({name, "_busy"}, {31'b0, busy}, 32'd0);
  endtask

  int latD, latI, dummy;

  initial begin
    memArr[16'h0040] = 16'hBEEF;
    memArr[16'h0200] = 16'hD00D;
    memArr[16'h0300] = 16'h1CE1;
    memArr[16'h0210] = 16'hD210;
    memArr[16'h0310] = 16'h1310;
    for (int k = 0; k < 6; k++) memArr[16'h0A10 + 16'(k * 16)] = 16'hA010 + 16'(k * 16);
    for (int k = 0; k < 5; k++) memArr[16'h0B00 + 16'(k)] = 16'hB000 + 16'(k);

    doReset();

    // Lone D read, latency 2.
    memLat = 2;
    cmdQ.push_back(mkCmd(1'b0, 16'h0040, 16'h0000));
    dQ.push_back(16'hBEEF);
    doD(16'h0040, 1'b0, 16'h0000, 1'b1, dummy);
    drainCheck("dread");
    check("dread_dcnt", {16'b0, d_grant_cnt}, 32'd1);
    check("dread_icnt", {16'b0, i_grant_cnt}, 32'd0);

    // D write-back; d_rdata must keep the previous read value.
    memLat = 3;
    cmdQ.push_back(mkCmd(1'b1, 16'h0100, 16'h1234));
    dQ.push_back(16'hBEEF);
    doD(16'h0100, 1'b1, 16'h1234, 1'b1, dummy);
    d_wr = 1'b0;
    drainCheck("dwrite");
    check("dwrite_mem", {16'b0, memArr[16'h0100]}, 32'h1234);
    check("dwrite_dcnt", {16'b0, d_grant_cnt}, 32'd2);

    // Simultaneous first requests: D wins, I issues in D's done cycle.
    doReset();
    memLat = 1;
    cmdQ.push_back(mkCmd(1'b0, 16'h0200, 16'h0000));
    cmdQ.push_back(mkCmd(1'b0, 16'h0300, 16'h0000));
    dQ.push_back(16'hD00D);
    iQ.push_back(16'h1CE1);
    fork
      doD(16'h0200, 1'b0, 16'h0000, 1'b1, latD);
      doI(16'h0300, 1'b1, latI);
    join
    check("tie_latD", latD, 32'd3);
    check("tie_latI", latI, 32'd6);
    drainCheck("tie");
    check("tie_icnt", {16'b0, i_grant_cnt}, 32'd1);
    check("tie_dcnt", {16'b0, d_grant_cnt}, 32'd1);
    // last_grant is now I, so a second tie must again go to D first.
    cmdQ.push_back(mkCmd(1'b0, 16'h0210, 16'h0000));
    cmdQ.push_back(mkCmd(1'b0, 16'h0310, 16'h0000));
    dQ.push_back(16'hD210);
    iQ.push_back(16'h1310);
    fork
      doD(16'h0210, 1'b0, 16'h0000, 1'b1, latD);
      doI(16'h0310, 1'b1, latI);
    join
    check("tie2_latD", latD, 32'd3);
    drainCheck("tie2");

    // Continuous requests: grants alternate D,I,D,I,D,I.
    doReset();
    memLat = 2;
    for (int k = 0; k < 6; k++) cmdQ.push_back(mkCmd(1'b0, 16'h0A10 + 16'(k * 16), 16'h0000));
    dQ.push_back(16'hA010); dQ.push_back(16'hA030); dQ.push_back(16'hA050);
    iQ.push_back(16'hA020); iQ.push_back(16'hA040); iQ.push_back(16'hA060);
    fork
      begin
        int l;
        doD(16'h0A10, 1'b0, 16'h0000, 1'b0, l);
        doD(16'h0A30, 1'b0, 16'h0000, 1'b0, l);
        doD(16'h0A50, 1'b0, 16'h0000, 1'b1, l);
      end
      begin
        int l;
        doI(16'h0A20, 1'b0, l);
        doI(16'h0A40, 1'b0, l);
        doI(16'h0A60, 1'b1, l);
      end
    join
    drainCheck("alt");
    check("alt_icnt", {16'b0, i_grant_cnt}, 32'd3);
    check("alt_dcnt", {16'b0, d_grant_cnt}, 32'd3);

    // Reset during BUSY_I abandons it; a stray mem_done afterwards sets sticky err.
    doReset();
    memLat = 6;
    cmdQ.push_back(mkCmd(1'b0, 16'h0500, 16'h0000));
    i_req = 1'b1;
    i_addr = 16'h0500;
    repeat (3) @(negedge clk);
    check("abort_busy_before", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    i_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_err", {31'b0, err}, 32'd0);
    check("abort_iQ", iQ.size(), 32'd0);
    @(posedge clk);
    #1 strayPulse = 1;
    repeat (2) @(negedge clk);
    check("stray_err", {31'b0, err}, 32'd1);
    repeat (5) @(negedge clk);
    check("stray_err_sticky", {31'b0, err}, 32'd1);
    check("stray_busy", {31'b0, busy}, 32'd0);

    // Five I grants: wide counter reads 5, 2-bit counter saturates at 3.
    doReset();
    memLat = 1;
    for (int k = 0; k < 5; k++) begin
      cmdQ.push_back(mkCmd(1'b0, 16'h0B00 + 16'(k), 16'h0000));
      iQ.push_back(16'hB000 + 16'(k));
      doI(16'h0B00 + 16'(k), 1'b1, dummy);
      @(negedge clk);
    end
    drainCheck("sat");
    check("sat_icnt16", {16'b0, i_grant_cnt}, 32'd5);
    check("sat_icnt2", {30'b0, i_grant_cnt2}, 32'd3);
    check("sat_dcnt2", {30'b0, d_grant_cnt2}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters: DATA_W, default 16, data width; CNT_W, default 16, grant-counter width.
REQ-002 One clock `clk`; reset `rst` is synchronous and active-high.
REQ-003 clk  input  1  system clock, all state updates on posedge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 i_req  input  1  I-cache fill request, read only; held until i_done.
REQ-006 i_addr  input  16  I-cache fill address.
REQ-007 i_done  output  1  one-cycle pulse; I transaction complete, i_rdata valid.
REQ-008 i_rdata  output  DATA_W  I fill data, held until the next I completion.
REQ-009 d_req  input  1  D-cache request, read or write; held until d_done.
REQ-010 d_wr  input  1  D request is a write-back when 1, a fill when 0.
REQ-011 d_addr  input  16  D request address.
REQ-012 d_wdata  input  DATA_W  D write-back data.
REQ-013 d_done  output  1  one-cycle pulse; D transaction complete.
REQ-014 d_rdata  output  DATA_W  D fill data, held until the next D read completion.
REQ-015 mem_en  output  1  one-cycle command strobe to shared memory.
REQ-016 mem_wr  output  1  command is a write; valid with mem_en.
REQ-017 mem_addr  output  16  command address, held stable from grant until done.
REQ-018 mem_wdata  output  DATA_W  write data, held stable from grant until done.
REQ-019 mem_done  input  1  memory completion pulse, arbitrary latency of 1 or more cycles after mem_en.
REQ-020 mem_rdata  input  DATA_W  read data, valid with mem_done.
REQ-021 busy  output  1  high in BUSY_I or BUSY_D.
REQ-022 i_grant_cnt, d_grant_cnt  output  CNT_W  saturating grant counters.
REQ-023 err  output  1  sticky protocol error flag.

Function
REQ-024 FSM states are IDLE, BUSY_I and BUSY_D; at most one memory transaction is outstanding.
REQ-025 IDLE: if an eligible request exists, register the grant, move to BUSY_x, and assert mem_en for exactly the next cycle with the latched command.
REQ-026 Both eligible: grant the requester not granted most recently (last_grant register); last_grant resets to I, so the first tie goes to D.
REQ-027 BUSY_x: hold all mem_* command outputs; on mem_done, register mem_rdata into x_rdata, pulse x_done next cycle, and return to IDLE in that same cycle.
REQ-028 A requester is ineligible during its own x_done cycle; the other requester may be granted in that cycle, giving back-to-back issue.
REQ-029 Minimum request-to-done latency is 3 cycles with a 1-cycle memory: grant, mem_en, mem_done, x_done.
REQ-030 d_rdata updates only on D reads; D writes pulse d_done and leave d_rdata unchanged.
REQ-031 mem_done while IDLE, or in the same cycle as mem_en, is ignored for data and sets err.
REQ-032 Grant counters increment once per grant and saturate at all-ones.

Reset
REQ-033 rst forces IDLE, last_grant=I, and clears mem_en, i_done, d_done, busy, err and both counters; rdata registers are cleared to 0.
REQ-034 rst mid-transaction abandons the transaction: no x_done is issued, and a later mem_done sets err only if it arrives after rst deasserts while IDLE.

Verification
REQ-035 d_req read 0x0040 alone, memory latency 2, mem_rdata=0xBEEF -> mem_en one cycle with mem_wr=0 and addr 0x0040; d_done pulses once with d_rdata=0xBEEF; d_grant_cnt=1.
REQ-036 i_req and d_req rise in the same cycle after reset -> D granted first; I issued in D's d_done cycle; i_done follows; last_grant=I.
REQ-037 d_req write 0x0100 with data 0x1234 -> mem_wr=1 with addr 0x0100 and data 0x1234 stable until mem_done; d_rdata unchanged.
REQ-038 i_req and d_req held continuously for 6 transactions -> grants alternate D,I,D,I,D,I; counters both 3.
REQ-039 rst asserted during BUSY_I -> no i_done; after reset busy=0 and err=0; a stray mem_done then sets err=1, which holds until the next rst.
REQ-040 CNT_W=2 with 5 I grants -> i_grant_cnt saturates at 3.
